// File: rtl/pending_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pending_encoder_pkg                                                  |
// | Shared types for the sticky pending-event priority encoder.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pending_encoder_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } penc_state_t;

endpackage
`default_nettype wire

// File: rtl/pending_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pending_encoder_if                                                   |
// | Request capture and indexed-event handshake bundle.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pending_encoder_if #(
  parameter int N = 8
);
  localparam int W  = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic          e;
  logic [N-1:0]  req;
  logic          out_valid;
  logic [W-1:0]  out_idx;
  logic          out_ready;
  logic [CW-1:0] pending_cnt;
  logic          overrun;

  // The encoder is the producer of the indexed event stream.
  modport master (
    input  e, req, out_ready,
    output out_valid, out_idx, pending_cnt, overrun
  );

  modport slave (
    output e, req, out_ready,
    input  out_valid, out_idx, pending_cnt, overrun
  );

endinterface
`default_nettype wire

// File: rtl/pending_encoder_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_enc                                                             |
// | Combinational lowest-set-bit encoder; bit i maps to index i.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] in_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pending_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pending_encoder                                                      |
// | Sticky pending register feeding a lowest-first indexed handshake.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  pending_encoder_if.master   bus
);

  localparam int W  = $clog2(N);
  localparam int CW = $clog2(N + 1);

  penc_state_t   state_q;
  logic [N-1:0]  pending_q;
  logic [N-1:0]  pending_d;
  logic          out_valid_q;
  logic [W-1:0]  out_idx_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          overrun_q;

  logic          hs;
  logic [N-1:0]  set_vec;
  logic [N-1:0]  clr_vec;
  logic          ovr_hit;
  logic [W-1:0]  cur_idx;
  logic          cur_found;
  logic [W-1:0]  rem_idx;
  logic          rem_found;

  assign hs      = out_valid_q & bus.out_ready;
  assign set_vec = bus.req & {N{bus.e}};

  // Set is OR'd in after the clear, so a same-cycle re-arrival stays pending.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < N; i++) begin
      clr_vec[i] = hs && (out_idx_q == W'(i));
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
    ovr_hit   = |(set_vec & pending_q & ~clr_vec);
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + CW'(pending_d[i]);
    end
  end

  prio_enc #(.N(N), .W(W)) u_enc_cur (
    .in_i    (pending_q),
    .idx_o   (cur_idx),
    .found_o (cur_found)
  );

  prio_enc #(.N(N), .W(W)) u_enc_rem (
    .in_i    (pending_d),
    .idx_o   (rem_idx),
    .found_o (rem_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      if (ovr_hit) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (cur_found) begin
            state_q     <= PRESENT;
            out_valid_q <= 1'b1;
            out_idx_q   <= cur_idx;
          end
        end
        PRESENT: begin
          if (hs) begin
            if (rem_found) begin
              out_idx_q <= rem_idx;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.pending_cnt = cnt_q;
  assign bus.overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pending_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pending_encoder                                                   |
// | Directed stimulus with an event-set reference model and literals.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pending_encoder;

  localparam int N = 8;

  logic clk;
  logic reset;

  pending_encoder_if #(.N(N)) bus ();

  pending_encoder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: a set of pending event numbers plus the presented one.
  bit [N-1:0] m_pend;
  bit         m_valid;
  int         m_idx;
  bit         m_ovr;
  bit         m_live = 1'b0;

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    bit [N-1:0] nxt;
    bit         accepted;
    if (reset) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_ovr   = 1'b0;
      m_live  = 1'b1;
    end else begin
      accepted = m_valid && bus.out_ready;
      for (int i = 0; i < N; i++) begin
        bit arrives;
        bit keeps;
        arrives = bus.e && bus.req[i];
        keeps   = m_pend[i] && !(accepted && (i == m_idx));
        nxt[i]  = arrives || keeps;
        if (arrives && keeps) m_ovr = 1'b1;
      end
      if (!m_valid) begin
        if (m_pend != 0) begin
          m_valid = 1'b1;
          m_idx   = lowest(m_pend);
        end
      end else if (accepted) begin
        if (nxt != 0) m_idx = lowest(nxt);
        else          m_valid = 1'b0;
      end
      m_pend = nxt;
    end
    #1;
    if (m_live) begin
      chk("model_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model_idx", 32'(bus.out_idx), 32'(m_idx));
      chk("model_cnt", 32'(bus.pending_cnt), 32'($countones(m_pend)));
      chk("model_overrun", 32'(bus.overrun), 32'(m_ovr));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input bit v, input int idx, input int cnt);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) chk({name, "_idx"}, 32'(bus.out_idx), 32'(idx));
    chk({name, "_cnt"}, 32'(bus.pending_cnt), 32'(cnt));
  endtask

  initial begin
    reset         = 1'b1;
    bus.e         = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    cyc(); cyc();
    expect_out("reset", 1'b0, 0, 0);
    chk("reset_idx", 32'(bus.out_idx), 32'd0);
    chk("reset_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b0;

    // Single event, consumer always ready.
    bus.e = 1'b1; bus.out_ready = 1'b1; bus.req = 8'b0000_0100;
    cyc(); expect_out("t1_cap", 1'b0, 0, 1);
    bus.req = '0;
    cyc(); expect_out("t1_pres", 1'b1, 2, 1);
    cyc(); expect_out("t1_done", 1'b0, 0, 0);
    cyc(); expect_out("t1_idle", 1'b0, 0, 0);

    // Three events under stall, then drained back to back.
    bus.out_ready = 1'b0; bus.req = 8'b1001_0010;
    cyc(); expect_out("t2_cap", 1'b0, 0, 3);
    bus.req = '0;
    for (int k = 0; k < 5; k++) begin
      cyc(); expect_out("t2_stall", 1'b1, 1, 3);
    end
    bus.out_ready = 1'b1;
    cyc(); expect_out("t2_seq4", 1'b1, 4, 2);
    cyc(); expect_out("t2_seq7", 1'b1, 7, 1);
    cyc(); expect_out("t2_empty", 1'b0, 0, 0);

    // Capture disabled.
    bus.e = 1'b0; bus.req = 8'hFF; bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); expect_out("t3_blocked", 1'b0, 0, 0);
      chk("t3_overrun", 32'(bus.overrun), 32'd0);
    end
    bus.e = 1'b1; bus.req = '0;

    // Duplicate of a stalled pending index sets sticky overrun.
    bus.req = 8'h08;
    cyc(); bus.req = '0;
    cyc(); expect_out("t4_pres", 1'b1, 3, 1);
    bus.req = 8'h08;
    cyc(); expect_out("t4_dup", 1'b1, 3, 1);
    chk("t4_overrun", 32'(bus.overrun), 32'd1);
    bus.req = '0;
    cyc(); chk("t4_sticky", 32'(bus.overrun), 32'd1);
    reset = 1'b1;
    cyc(); reset = 1'b0;
    chk("t4_rst_overrun", 32'(bus.overrun), 32'd0);

    // Re-arrival in the handshake cycle is a fresh event, not an overrun.
    bus.req = 8'h08;
    cyc(); bus.req = '0;
    cyc(); expect_out("t4b_pres", 1'b1, 3, 1);
    bus.out_ready = 1'b1; bus.req = 8'h08;
    cyc(); expect_out("t4b_repres", 1'b1, 3, 1);
    chk("t4b_no_overrun", 32'(bus.overrun), 32'd0);
    bus.out_ready = 1'b0; bus.req = '0;
    cyc(); expect_out("t4b_hold", 1'b1, 3, 1);
    bus.out_ready = 1'b1;
    cyc(); expect_out("t4b_done", 1'b0, 0, 0);
    bus.out_ready = 1'b0;

    // Lower index arriving mid-presentation does not pre-empt.
    bus.req = 8'h20;
    cyc(); bus.req = '0;
    cyc(); expect_out("t5_pres", 1'b1, 5, 1);
    bus.req = 8'h01;
    cyc(); expect_out("t5_nopreempt", 1'b1, 5, 2);
    bus.req = '0;
    cyc(); expect_out("t5_hold", 1'b1, 5, 2);
    bus.out_ready = 1'b1;
    cyc(); expect_out("t5_next", 1'b1, 0, 1);
    cyc(); expect_out("t5_done", 1'b0, 0, 0);
    bus.out_ready = 1'b0;

    // Reset while presenting with four pending and requests active.
    bus.req = 8'h0F;
    cyc(); bus.req = '0;
    cyc(); expect_out("t6_pres", 1'b1, 0, 4);
    bus.req = 8'h01;
    cyc(); chk("t6_overrun", 32'(bus.overrun), 32'd1);
    reset = 1'b1; bus.req = 8'hFF;
    cyc(); expect_out("t6_rst", 1'b0, 0, 0);
    chk("t6_rst_idx", 32'(bus.out_idx), 32'd0);
    chk("t6_rst_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b0; bus.req = '0;
    cyc(); expect_out("t6_after", 1'b0, 0, 0);
    cyc(); expect_out("t6_after2", 1'b0, 0, 0);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
